matrix_vec_mult_param: RTL and testbench

Parametrised matrix-vector multiply engine computing c = A·b for an N×N matrix A and an N-element vector b.
- Snapshots both operands on `start` into internal row buffers.
- Feeds a skewed, systolic row of N MAC lanes.
- Adds signed/unsigned operand mode, accumulate-across-runs mode, per-row overflow flags and a busy indicator.

It is the next-generation drop-in for the fixed 8×8 unsigned matrix multiplier in the MiniLab datapath.

---
 rtl/matrix_vec_mult_param.sv | 197 +++++++++++++++++++
 tb/tb_matrix_vec_mult_param.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_vec_mult_param.sv
// matrix_vec_mult_param: computes c = A*b for an N x N matrix and an N-element vector.
// Operands are snapshotted on start. The sweep runs through a skewed row of N MAC lanes:
// lane i sees b[k] one cycle after lane i-1, so lane i adds a[i][k]*b[k] in sweep cycle k+i.
// Results are held between runs and can optionally be accumulated across runs.

module matrix_vec_mult_param #(
    parameter int unsigned N      = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 24
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            clr,
    input  logic                            signed_mode,
    input  logic                            accum,
    input  logic [N-1:0][N-1:0][DATA_W-1:0] a_data,
    input  logic [N-1:0][DATA_W-1:0]        b_data,
    output logic [N-1:0][ACC_W-1:0]         c_out,
    output logic [N-1:0]                    ovf,
    output logic                            busy,
    output logic                            done
);

    // Column index width, sweep counter width and product width.
    localparam int unsigned KW = $clog2(N);
    localparam int unsigned CW = $clog2(2 * N);
    localparam int unsigned PW = 2 * DATA_W;

    // Sweep counter value of the final accumulation cycle, and the end of the b feed.
    localparam logic [CW-1:0] LastCnt = CW'(2 * N - 2);
    localparam logic [CW-1:0] FeedEnd = CW'(N);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    // Architectural state
    state_e                          state_q, state_d;
    logic [N-1:0][N-1:0][DATA_W-1:0] a_buf_q, a_buf_d;
    logic [N-1:0][DATA_W-1:0]        b_buf_q, b_buf_d;
    logic                            sgn_q, sgn_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic [N-1:0][ACC_W-1:0]         acc_q, acc_d;
    logic [N-1:0]                    ovf_q, ovf_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;

    // Skew pipeline: stage j carries the b element (and its column index) for lane j+1.
    logic [N-2:0]                    skew_v_q, skew_v_d;
    logic [N-2:0][DATA_W-1:0]        skew_b_q, skew_b_d;
    logic [N-2:0][KW-1:0]            skew_k_q, skew_k_d;

    // Per-lane operands seen this cycle
    logic [N-1:0]                    lane_v;
    logic [N-1:0][DATA_W-1:0]        lane_b;
    logic [N-1:0][KW-1:0]            lane_k;

    // Per-lane datapath
    logic [DATA_W-1:0]               a_el    [N];
    logic signed [PW-1:0]            prod_s  [N];
    logic [PW-1:0]                   prod_u  [N];
    logic [ACC_W-1:0]                addend  [N];
    logic [ACC_W:0]                  sum_w   [N];
    logic [N-1:0]                    add_ovf;

    // Lane operand routing: lane 0 reads the b buffer directly, later lanes read the skew chain.
    always_comb begin
        lane_v[0] = (cnt_q < FeedEnd);
        lane_b[0] = b_buf_q[cnt_q[KW-1:0]];
        lane_k[0] = cnt_q[KW-1:0];
        for (int i = 1; i < N; i++) begin
            lane_v[i] = skew_v_q[i-1];
            lane_b[i] = skew_b_q[i-1];
            lane_k[i] = skew_k_q[i-1];
        end
    end

    // MAC lanes: product in the latched mode, extended to ACC_W, add with overflow detect.
    always_comb begin
        add_ovf = '0;
        for (int i = 0; i < N; i++) begin
            a_el[i]   = a_buf_q[i][lane_k[i]];
            prod_s[i] = PW'($signed(a_el[i])) * PW'($signed(lane_b[i]));
            prod_u[i] = PW'(a_el[i]) * PW'(lane_b[i]);
            addend[i] = sgn_q ? ACC_W'(prod_s[i]) : ACC_W'(prod_u[i]);
            sum_w[i]  = {1'b0, acc_q[i]} + {1'b0, addend[i]};
            if (sgn_q) begin
                // Like-signed operands whose sum changes sign
                add_ovf[i] = (acc_q[i][ACC_W-1] == addend[i][ACC_W-1]) &&
                             (sum_w[i][ACC_W-1] != acc_q[i][ACC_W-1]);
            end else begin
                add_ovf[i] = sum_w[i][ACC_W];
            end
        end
    end

    // Next-state logic: clr beats start; start is only honoured outside CALC.
    always_comb begin
        state_d  = state_q;
        a_buf_d  = a_buf_q;
        b_buf_d  = b_buf_q;
        sgn_d    = sgn_q;
        cnt_d    = cnt_q;
        skew_v_d = skew_v_q;
        skew_b_d = skew_b_q;
        skew_k_d = skew_k_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        busy_d   = busy_q;
        done_d   = done_q;

        if (clr) begin
            state_d  = StIdle;
            cnt_d    = '0;
            skew_v_d = '0;
            acc_d    = '0;
            ovf_d    = '0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
        end else if (start && (state_q != StCalc)) begin
            state_d  = StCalc;
            a_buf_d  = a_data;
            b_buf_d  = b_data;
            sgn_d    = signed_mode;
            cnt_d    = '0;
            skew_v_d = '0;
            busy_d   = 1'b1;
            done_d   = 1'b0;
            if (!accum) begin
                acc_d = '0;
                ovf_d = '0;
            end
        end else if (state_q == StCalc) begin
            cnt_d = cnt_q + 1'b1;
            // Each lane's operand moves one lane down per cycle
            for (int i = 0; i < N - 1; i++) begin
                skew_v_d[i] = lane_v[i];
                skew_b_d[i] = lane_b[i];
                skew_k_d[i] = lane_k[i];
            end
            // Lanes outside their window hold their value
            for (int i = 0; i < N; i++) begin
                if (lane_v[i]) begin
                    acc_d[i] = sum_w[i][ACC_W-1:0];
                    if (add_ovf[i]) begin
                        ovf_d[i] = 1'b1;
                    end
                end
            end
            if (cnt_q == LastCnt) begin
                state_d = StDone;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_buf_q  <= '0;
            b_buf_q  <= '0;
            sgn_q    <= 1'b0;
            cnt_q    <= '0;
            skew_v_q <= '0;
            skew_b_q <= '0;
            skew_k_q <= '0;
            acc_q    <= '0;
            ovf_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_buf_q  <= a_buf_d;
            b_buf_q  <= b_buf_d;
            sgn_q    <= sgn_d;
            cnt_q    <= cnt_d;
            skew_v_q <= skew_v_d;
            skew_b_q <= skew_b_d;
            skew_k_q <= skew_k_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign c_out = acc_q;
    assign ovf   = ovf_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_matrix_vec_mult_param.sv
// Bench for matrix_vec_mult_param: an edge-by-edge behavioural model of the 8x8/24-bit
// instance checked every cycle, plus literal expectations for both 24-bit and 16-bit instances.

module tb_matrix_vec_mult_param;

    typedef logic [7:0][7:0][7:0] mat_t;
    typedef logic [7:0][7:0]      vec_t;

    localparam longint Mask = 64'hFF_FFFF;

    logic clk;
    logic rst, start, clr, sm, acc;
    mat_t a;
    vec_t b;

    logic [7:0][23:0] c24;
    logic [7:0]       ovf24;
    logic             busy24, done24;
    logic [7:0][15:0] c16;
    logic [7:0]       ovf16;
    logic             busy16, done16;

    int errs   = 0;
    int checks = 0;

    matrix_vec_mult_param #(.N(8), .DATA_W(8), .ACC_W(24)) u_dut (
        .clk(clk), .rst(rst), .start(start), .clr(clr), .signed_mode(sm), .accum(acc),
        .a_data(a), .b_data(b), .c_out(c24), .ovf(ovf24), .busy(busy24), .done(done24)
    );

    matrix_vec_mult_param #(.N(8), .DATA_W(8), .ACC_W(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start), .clr(clr), .signed_mode(sm), .accum(acc),
        .a_data(a), .b_data(b), .c_out(c16), .ovf(ovf16), .busy(busy16), .done(done16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model of the 24-bit instance ----------------
    bit               m_live = 1'b0;
    bit               m_run  = 1'b0;
    bit               m_done = 1'b0;
    bit               m_sgn  = 1'b0;
    int               m_cyc  = 0;
    mat_t             m_a;
    vec_t             m_b;
    logic [7:0][23:0] m_c;
    logic [7:0]       m_ovf;

    // Applies the effect of one rising edge, given the inputs present at that edge.
    task automatic model_step();
        longint p, pa, s;
        int     k;
        bit     o;
        if (rst) begin
            m_live = 1'b1;
            m_run  = 1'b0;
            m_done = 1'b0;
            m_cyc  = 0;
            m_c    = '0;
            m_ovf  = '0;
        end else if (clr) begin
            m_run  = 1'b0;
            m_done = 1'b0;
            m_c    = '0;
            m_ovf  = '0;
        end else if (start && !m_run) begin
            m_a    = a;
            m_b    = b;
            m_sgn  = sm;
            if (!acc) begin
                m_c   = '0;
                m_ovf = '0;
            end
            m_run  = 1'b1;
            m_done = 1'b0;
            m_cyc  = 0;
        end else if (m_run) begin
            m_cyc++;
            // Edge E0+m_cyc is sweep cycle m_cyc-1: lane i adds term k = m_cyc-1-i
            for (int i = 0; i < 8; i++) begin
                k = m_cyc - 1 - i;
                if (k >= 0 && k < 8) begin
                    if (m_sgn) p = longint'($signed(m_a[i][k])) * longint'($signed(m_b[k]));
                    else       p = longint'(m_a[i][k]) * longint'(m_b[k]);
                    pa = p & Mask;
                    s  = longint'(m_c[i]) + pa;
                    if (m_sgn) o = (m_c[i][23] == pa[23]) && (s[23] != m_c[i][23]);
                    else       o = (s > Mask);
                    if (o) m_ovf[i] = 1'b1;
                    m_c[i] = 24'(s);
                end
            end
            if (m_cyc == 15) begin
                m_run  = 1'b0;
                m_done = 1'b1;
            end
        end
    endtask

    // Model update on each rising edge, comparison on the following falling edge.
    initial begin : model_compare
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            if (m_live) begin
                chk("cycle c_out", 256'(c24), 256'(m_c));
                chk("cycle ovf",   256'(ovf24), 256'(m_ovf));
                chk("cycle busy",  256'(busy24), 256'(m_run));
                chk("cycle done",  256'(done24), 256'(m_done));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Presents operands with start for one edge (E0), then scrambles the operand inputs.
    task automatic go(input mat_t av, input vec_t bv, input logic sgn, input logic ac);
        a     = av;
        b     = bv;
        sm    = sgn;
        acc   = ac;
        start = 1'b1;
        @(posedge clk);
        #3;
        start = 1'b0;
        sm    = ~sgn;
        acc   = ~ac;
        for (int i = 0; i < 8; i++) begin
            b[i] = 8'($urandom);
            for (int j = 0; j < 8; j++) a[i][j] = 8'($urandom);
        end
    endtask

    // Waits (bounded) for done; returns clocks since E0 and the number of busy cycles seen.
    task automatic wait_done(output int lat, output int bn);
        bn  = busy24 ? 1 : 0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (busy24) bn++;
            if (done24) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) begin
            errs++;
            checks++;
            $display("FAIL done timeout: got no done expected done within 40 clocks");
        end
        #2;
    endtask

    mat_t m_ident, m_rows, m_ff, m_80, m_zero;
    vec_t v_18, v_02, v_ff, v_80, v_zero;
    int   lat, bn;

    initial begin : stimulus
        for (int i = 0; i < 8; i++) begin
            v_18[i]   = 8'(i + 1);
            v_02[i]   = 8'h02;
            v_ff[i]   = 8'hFF;
            v_80[i]   = 8'h80;
            v_zero[i] = 8'h00;
            for (int j = 0; j < 8; j++) begin
                m_ident[i][j] = (i == j) ? 8'd1 : 8'd0;
                m_rows[i][j]  = 8'(i + 1);
                m_ff[i][j]    = 8'hFF;
                m_80[i][j]    = 8'h80;
                m_zero[i][j]  = 8'h00;
            end
        end

        rst = 1'b1; start = 1'b0; clr = 1'b0; sm = 1'b0; acc = 1'b0;
        a = '0; b = '0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        chk("reset c_out", 256'(c24), 0);
        chk("reset ovf",   256'(ovf24), 0);
        chk("reset busy",  256'(busy24), 0);
        chk("reset done",  256'(done24), 0);
        chk("reset c16",   256'(c16), 0);

        // Identity: c = b, 15-clock latency, 15 busy cycles
        go(m_ident, v_18, 1'b0, 1'b0);
        wait_done(lat, bn);
        chk("ident latency", 256'(lat), 15);
        chk("ident busy cycles", 256'(bn), 15);
        for (int i = 0; i < 8; i++) chk("ident c_out", 256'(c24[i]), 256'(i + 1));
        chk("ident ovf", 256'(ovf24), 0);

        // Skew: row i all (i+1), b=1..8; lane i final (36*(i+1)) exactly at edge E0+8+i
        go(m_rows, v_18, 1'b0, 1'b0);
        for (int m = 1; m <= 15; m++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 8; i++) begin
                if (m == 7 + i) chk("skew before final", 256'(c24[i]), 256'(28 * (i + 1)));
                if (m == 8 + i) chk("skew at final", 256'(c24[i]), 256'(36 * (i + 1)));
            end
        end
        #2;

        // Signed: 8 x (-1 * 2) = -16
        go(m_ff, v_02, 1'b1, 1'b0);
        wait_done(lat, bn);
        for (int i = 0; i < 8; i++) chk("signed c_out", 256'(c24[i]), 24'hFFFFF0);
        chk("signed ovf", 256'(ovf24), 0);

        // Unsigned: 8 x 255 * 2 = 4080, then back-to-back accumulate to 8160
        go(m_ff, v_02, 1'b0, 1'b0);
        wait_done(lat, bn);
        for (int i = 0; i < 8; i++) chk("unsigned c_out", 256'(c24[i]), 24'h000FF0);
        go(m_ff, v_02, 1'b0, 1'b1);
        chk("accum done falls", 256'(done24), 0);
        wait_done(lat, bn);
        chk("accum latency", 256'(lat), 15);
        for (int i = 0; i < 8; i++) chk("accum c_out", 256'(c24[i]), 256'(8160));

        // Overflow: 8 x 255*255 = 520200; 16-bit wraps to 0xF008 with ovf set
        go(m_ff, v_ff, 1'b0, 1'b0);
        wait_done(lat, bn);
        for (int i = 0; i < 8; i++) chk("ovf16 c_out", 256'(c16[i]), 16'hF008);
        chk("ovf16 flags", 256'(ovf16), 8'hFF);
        chk("ovf24 c_out lane7", 256'(c24[7]), 24'h07F008);

        // clr with start in DONE: everything cleared, no sweep
        clr = 1'b1; start = 1'b1; a = m_ff; b = v_ff; acc = 1'b0; sm = 1'b0;
        @(posedge clk);
        #3;
        clr = 1'b0; start = 1'b0;
        chk("clr c_out", 256'(c24), 0);
        chk("clr ovf16", 256'(ovf16), 0);
        chk("clr done", 256'(done24), 0);
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            #3;
            chk("clr busy", 256'(busy24), 0);
        end

        // Signed overflow on 16 bits: 8 x 16384 wraps to 0
        go(m_80, v_80, 1'b1, 1'b0);
        wait_done(lat, bn);
        chk("sovf16 c_out lane0", 256'(c16[0]), 0);
        chk("sovf16 flags", 256'(ovf16), 8'hFF);
        chk("sovf24 c_out lane3", 256'(c24[3]), 24'h020000);

        // Zero data with accum=0 clears the sticky flags
        go(m_zero, v_zero, 1'b0, 1'b0);
        wait_done(lat, bn);
        chk("zero ovf16", 256'(ovf16), 0);
        chk("zero c16", 256'(c16), 0);

        // rst mid-sweep, then a fresh run
        go(m_ff, v_02, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b0;
        chk("rst c_out", 256'(c24), 0);
        chk("rst busy", 256'(busy24), 0);
        chk("rst done", 256'(done24), 0);
        chk("rst c16", 256'(c16), 0);
        go(m_ident, v_18, 1'b0, 1'b0);
        wait_done(lat, bn);
        chk("post rst latency", 256'(lat), 15);
        for (int i = 0; i < 8; i++) chk("post rst c_out", 256'(c24[i]), 256'(i + 1));

        // start mid-sweep is ignored
        go(m_rows, v_18, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #3;
        a = m_ff; b = v_ff; sm = 1'b1; acc = 1'b0; start = 1'b1;
        @(posedge clk);
        #3;
        start = 1'b0;
        wait_done(lat, bn);
        for (int i = 0; i < 8; i++) chk("ignored start c_out", 256'(c24[i]), 256'(36 * (i + 1)));
        chk("ignored start ovf", 256'(ovf24), 0);

        repeat (2) @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
